// File: rtl/button_events.sv
// button_events: turns a debounced button level into single-cycle event strobes
// (press, release, click, long press, auto-repeat) plus a "held" level.
// Hold time is measured in rising edges of the shared m_f time-base.
module button_events #(
    parameter int LONG_TICKS   = 16,
    parameter int REPEAT_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic m_f,
    input  logic db_button,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    // Counter values at which the hold thresholds are reached.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, mf_q, armed_q;
    logic             press_q, release_q, click_q, long_q, repeat_q, held_q;
    logic             press_d, release_d, click_d, long_d, repeat_d;
    logic             tick, rise, fall;

    // Edge detectors. A button that is already down when reset ends must be
    // released once (armed) before it can generate a press.
    assign tick = m_f & ~mf_q;
    assign rise = db_button & ~db_q & armed_q;
    assign fall = ~db_button & db_q;

    // Input history registers and the one-shot arm flag.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q    <= 1'b0;
            mf_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            db_q <= db_button;
            mf_q <= m_f;
            if (!db_button) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Next-state, counter and pulse decode; release beats a coincident tick.
    // NOTE: every signal is given a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (tick) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (tick) begin
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset truncates any pulse in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= (state_d != IDLE);
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Consumer end of the debounced button path: takes `db_button` from the debouncer and decodes it into single-cycle event pulses.
- Events: press, release, short click, long press, auto-repeat.
- Time is measured in slow-tick periods derived from the shared `m_f` strobe, so hold thresholds track the same time base the debouncer uses.
- Outputs feed the processor's input/control logic as clean one-cycle strobes.

Parameters:
- LONG_TICKS, 16, `m_f` rising edges of continuous hold before `long_press` fires (legal range 2..2^CNT_W).
- REPEAT_TICKS, 4, `m_f` rising edges between successive `repeat_pulse` while held after a long press (legal range 1..2^CNT_W).
- CNT_W, 8, width of the internal tick counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_f  input  1  slow time-base square wave (synchronous to clk); only its rising edge is used.
- db_button  input  1  debounced button level, 1 = pressed.
- press_pulse  output  1  one-cycle strobe on press.
- release_pulse  output  1  one-cycle strobe on release.
- click_pulse  output  1  one-cycle strobe on release before the long threshold.
- long_press  output  1  one-cycle strobe when the hold reaches LONG_TICKS.
- repeat_pulse  output  1  one-cycle strobe every REPEAT_TICKS while in the long hold.
- held  output  1  level, 1 while the FSM is in PRESSED or HELD.

Behaviour:
- Reset (async, active-high):
  - State = IDLE, counter = 0, all outputs = 0.
  - `db_q` = 0, `mf_q` = 0, `armed` = 0.
- Input registers, updated every clk edge:
  - `db_q` <= `db_button`; `mf_q` <= `m_f`.
  - `tick` = `m_f` & ~`mf_q` (combinational).
  - `rise` = `db_button` & ~`db_q` & `armed`.
  - `fall` = ~`db_button` & `db_q`.
- `armed` is set on the first edge where `db_button` = 0 and stays set until reset. A button held through reset therefore produces no press until it has been released once.
- All outputs are registered. Each pulse is high for exactly one clk cycle, in the cycle following the edge at which its condition was sampled. All pulses default to 0 every cycle.
- FSM states are IDLE, PRESSED and HELD. `held` = (state != IDLE), registered.
- IDLE:
  - On `rise`: `press_pulse` = 1, counter = 0, go to PRESSED.
  - A `tick` on the same edge is ignored.
- PRESSED:
  - `fall` has priority: `release_pulse` = 1, `click_pulse` = 1, go to IDLE, counter = 0.
  - Otherwise, on `tick`: if counter = LONG_TICKS-1, then `long_press` = 1, counter = 0, go to HELD; else counter + 1.
- HELD:
  - `fall` has priority: `release_pulse` = 1, no `click_pulse`, go to IDLE, counter = 0.
  - Otherwise, on `tick`: if counter = REPEAT_TICKS-1, then `repeat_pulse` = 1, counter = 0; else counter + 1.
- Simultaneous events: release and tick on the same edge means release wins and no `long_press`/`repeat_pulse` is issued.
- Counter arithmetic: unsigned CNT_W bits; it never wraps, because it is cleared at threshold.
- A `db_button` glitch shorter than one clk cycle is not possible (the input is already debounced). Press-release-press with one cycle of 0 produces release then press pulses on consecutive edges.
- Reset mid-operation: immediately IDLE with all outputs 0. A pulse in flight is truncated, and no release event is generated.

Test Plan (bench uses LONG_TICKS=4, REPEAT_TICKS=2, `m_f` period 8 clk cycles):
- Reset then `db_button` 0 -> 1, held for 2 `m_f` rising edges, then released:
  - exactly one `press_pulse` (1 cycle after the edge sampling 1);
  - `held` = 1 during the hold;
  - one `release_pulse` + `click_pulse` on release;
  - `long_press` never asserted.
- Hold for 4 `m_f` rising edges -> `long_press` one cycle after the 4th tick edge, `held` stays 1. Continue hold for 6 more ticks -> exactly 3 `repeat_pulse`, one after every 2nd tick. On release -> `release_pulse` = 1, `click_pulse` = 0.
- `db_button` 1 during and after reset deassertion -> no `press_pulse`. After `db_button` goes 0 then 1 again -> one `press_pulse`.
- Release on the same clk edge as the 4th `m_f` rising edge -> `release_pulse` + `click_pulse`, no `long_press`, state returns to IDLE.
- Assert `rst` for 2 cycles while in HELD -> all outputs 0 asynchronously, `held` = 0. After reset with button still high -> no pulses until a release/press cycle.
- `db_button` low for exactly 1 clk between two presses -> `release_pulse` then `press_pulse` on consecutive cycles, counter restarts from 0 (`long_press` requires 4 fresh ticks).
